// File: rtl/vx_barrier_tracker_pkg.sv
// Shared types and sizing for the barrier tracker: request/release records and id widths.
package VX_gpu_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 4;
  localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  typedef struct packed {
    logic [NW_BITS-1:0] wid;
    logic [NB_BITS-1:0] bar_id;
    logic [NW_BITS-1:0] size_m1;
  } barrier_req_t;

  typedef struct packed {
    logic [NB_BITS-1:0]   bar_id;
    logic [NUM_WARPS-1:0] mask;
  } barrier_rel_t;

endpackage

// File: rtl/vx_barrier_slot.sv
// One barrier slot: arrival count, latched expected size and member mask.
// done fires combinationally in the cycle the final warp arrives; done_mask includes that warp.
module vx_barrier_slot
  import VX_gpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arrive,
  input  logic [NW_BITS-1:0]   wid,
  input  logic [NW_BITS-1:0]   size_m1,
  output logic                 done,
  output logic                 busy,
  output logic [NUM_WARPS-1:0] mask,
  output logic [NUM_WARPS-1:0] done_mask
);

  logic [NW_BITS:0]     count_reg;
  logic [NW_BITS-1:0]   size_reg;
  logic [NUM_WARPS-1:0] mask_reg;

  logic                 armed;
  logic [NW_BITS-1:0]   size_eff;
  logic [NW_BITS:0]     count_next;
  logic [NW_BITS:0]     target;
  logic [NUM_WARPS-1:0] wid_bit;

  assign armed      = (count_reg != '0);
  // The first arrival defines the barrier size; later arrivals' size fields are ignored.
  assign size_eff   = armed ? size_reg : size_m1;
  assign count_next = count_reg + (NW_BITS+1)'(1);
  assign target     = {1'b0, size_eff} + (NW_BITS+1)'(1);
  assign wid_bit    = NUM_WARPS'(1) << wid;

  assign done      = arrive && (count_next == target);
  assign busy      = armed;
  assign mask      = mask_reg;
  assign done_mask = mask_reg | wid_bit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
      size_reg  <= '0;
      mask_reg  <= '0;
    end else if (done) begin
      count_reg <= '0;
      size_reg  <= '0;
      mask_reg  <= '0;
    end else if (arrive) begin
      if (!armed) size_reg <= size_m1;
      count_reg <= count_next;
      mask_reg  <= mask_reg | wid_bit;
    end
  end

endmodule

// File: rtl/vx_barrier_tracker.sv
// Barrier tracker: decodes warp arrivals into slots, rejects duplicates, emits one release at a time.
// Optional performance counters are built when BARRIER_PERF_EN is defined.
module vx_barrier_tracker
  import VX_gpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NW_BITS-1:0]      req_wid,
  input  logic [NB_BITS-1:0]      req_bar_id,
  input  logic [NW_BITS-1:0]      req_size_m1,
  output logic                    rel_valid,
  input  logic                    rel_ready,
  output logic [NB_BITS-1:0]      rel_bar_id,
  output logic [NUM_WARPS-1:0]    rel_mask,
  output logic [NUM_WARPS-1:0]    stalled_mask,
  output logic [NUM_BARRIERS-1:0] busy_mask,
  output logic                    err_pulse
`ifdef BARRIER_PERF_EN
  ,
  output logic [43:0]             perf_stall_cycles,
  output logic [31:0]             perf_releases
`endif
);

  barrier_req_t req;
  barrier_rel_t rel_reg;
  barrier_rel_t rel_next;
  logic         rel_valid_reg;
  logic         err_reg;

  logic                    accept;
  logic                    dup;
  logic                    any_done;
  logic [NUM_BARRIERS-1:0] arrive;
  logic [NUM_BARRIERS-1:0] slot_done;
  logic [NUM_WARPS-1:0]    slot_mask      [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    slot_done_mask [NUM_BARRIERS];

  assign req       = '{wid: req_wid, bar_id: req_bar_id, size_m1: req_size_m1};
  assign req_ready = ~rel_valid_reg | rel_ready;
  assign accept    = req_valid & req_ready;
  assign dup       = stalled_mask[req.wid];

  generate
    for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_slot
      assign arrive[gi] = accept & ~dup & (req.bar_id == NB_BITS'(gi));
      vx_barrier_slot u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .arrive    (arrive[gi]),
        .wid       (req.wid),
        .size_m1   (req.size_m1),
        .done      (slot_done[gi]),
        .busy      (busy_mask[gi]),
        .mask      (slot_mask[gi]),
        .done_mask (slot_done_mask[gi])
      );
    end
  endgenerate

  always_comb begin
    stalled_mask = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) stalled_mask |= slot_mask[i];
  end

  // Only one arrival per cycle, so at most one slot completes; the encoder just picks it.
  always_comb begin
    any_done = 1'b0;
    rel_next = '0;
    for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
      if (slot_done[i]) begin
        any_done        = 1'b1;
        rel_next.bar_id = NB_BITS'(i);
        rel_next.mask   = slot_done_mask[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rel_valid_reg <= 1'b0;
      rel_reg       <= '0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= accept & dup;
      if (any_done) begin
        rel_valid_reg <= 1'b1;
        rel_reg       <= rel_next;
      end else if (rel_ready) begin
        rel_valid_reg <= 1'b0;
        rel_reg       <= '0;
      end
    end
  end

  assign rel_valid  = rel_valid_reg;
  assign rel_bar_id = rel_reg.bar_id;
  assign rel_mask   = rel_reg.mask;
  assign err_pulse  = err_reg;

`ifdef BARRIER_PERF_EN
  logic [43:0] stall_cycles_reg;
  logic [31:0] releases_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles_reg <= '0;
      releases_reg     <= '0;
    end else begin
      if (stalled_mask != '0)          stall_cycles_reg <= stall_cycles_reg + 44'd1;
      if (rel_valid_reg && rel_ready)  releases_reg     <= releases_reg + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cycles_reg;
  assign perf_releases     = releases_reg;
`endif

endmodule

// File: tb/tb_vx_barrier_tracker.sv
// Directed bench for vx_barrier_tracker; perf counter checks compile in with BARRIER_PERF_EN.
module tb_vx_barrier_tracker;
  import VX_gpu_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    req_valid;
  logic                    req_ready;
  logic [NW_BITS-1:0]      req_wid;
  logic [NB_BITS-1:0]      req_bar_id;
  logic [NW_BITS-1:0]      req_size_m1;
  logic                    rel_valid;
  logic                    rel_ready;
  logic [NB_BITS-1:0]      rel_bar_id;
  logic [NUM_WARPS-1:0]    rel_mask;
  logic [NUM_WARPS-1:0]    stalled_mask;
  logic [NUM_BARRIERS-1:0] busy_mask;
  logic                    err_pulse;
`ifdef BARRIER_PERF_EN
  logic [43:0]             perf_stall_cycles;
  logic [31:0]             perf_releases;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_barrier_tracker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wid      (req_wid),
    .req_bar_id   (req_bar_id),
    .req_size_m1  (req_size_m1),
    .rel_valid    (rel_valid),
    .rel_ready    (rel_ready),
    .rel_bar_id   (rel_bar_id),
    .rel_mask     (rel_mask),
    .stalled_mask (stalled_mask),
    .busy_mask    (busy_mask),
    .err_pulse    (err_pulse)
`ifdef BARRIER_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_releases     (perf_releases)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arrive(input int wid, input int bar, input int size_m1);
    req_valid   = 1'b1;
    req_wid     = NW_BITS'(wid);
    req_bar_id  = NB_BITS'(bar);
    req_size_m1 = NW_BITS'(size_m1);
    step();
    req_valid = 1'b0;
    $display("arrival wid=%0d bar=%0d size_m1=%0d -> rel_valid=%0b rel_bar=%0d rel_mask=%b stalled=%b busy=%b err=%0b",
             wid, bar, size_m1, rel_valid, rel_bar_id, rel_mask, stalled_mask, busy_mask, err_pulse);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    step();
    $display("idle -> rel_valid=%0b rel_bar=%0d rel_mask=%b stalled=%b busy=%b err=%0b",
             rel_valid, rel_bar_id, rel_mask, stalled_mask, busy_mask, err_pulse);
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_wid     = '0;
    req_bar_id  = '0;
    req_size_m1 = '0;
    rel_ready   = 1'b1;
    step();
    step();
    chk("rst_rel_valid", 64'(rel_valid), 64'd0);
    chk("rst_rel_mask", 64'(rel_mask), 64'd0);
    chk("rst_rel_bar_id", 64'(rel_bar_id), 64'd0);
    chk("rst_stalled", 64'(stalled_mask), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_err", 64'(err_pulse), 64'd0);
    reset_n = 1'b1;

    // Scenario 1: four warps on bar 0, size 4
    arrive(0, 0, 3);
    chk("s1_stalled_a0", 64'(stalled_mask), 64'b0001);
    chk("s1_busy_a0", 64'(busy_mask), 64'b0001);
    chk("s1_rel_valid_a0", 64'(rel_valid), 64'd0);
    arrive(1, 0, 3);
    chk("s1_stalled_a1", 64'(stalled_mask), 64'b0011);
    arrive(2, 0, 3);
    chk("s1_stalled_a2", 64'(stalled_mask), 64'b0111);
    chk("s1_rel_valid_a2", 64'(rel_valid), 64'd0);
    arrive(3, 0, 3);
    chk("s1_rel_valid", 64'(rel_valid), 64'd1);
    chk("s1_rel_mask", 64'(rel_mask), 64'b1111);
    chk("s1_rel_bar_id", 64'(rel_bar_id), 64'd0);
    chk("s1_stalled_done", 64'(stalled_mask), 64'd0);
    chk("s1_busy_done", 64'(busy_mask), 64'd0);
    idle();
    chk("s1_rel_cleared", 64'(rel_valid), 64'd0);
`ifdef BARRIER_PERF_EN
    chk("s1_perf_stall", 64'(perf_stall_cycles), 64'd3);
    chk("s1_perf_rel", 64'(perf_releases), 64'd1);
`endif

    // Scenario 2: single-warp barrier
    arrive(2, 1, 0);
    chk("s2_rel_valid", 64'(rel_valid), 64'd1);
    chk("s2_rel_mask", 64'(rel_mask), 64'b0100);
    chk("s2_rel_bar_id", 64'(rel_bar_id), 64'd1);
    chk("s2_stalled", 64'(stalled_mask), 64'd0);
    chk("s2_busy", 64'(busy_mask), 64'd0);
    idle();
    chk("s2_rel_cleared", 64'(rel_valid), 64'd0);
    chk("s2_rel_mask_cleared", 64'(rel_mask), 64'd0);

    // Scenario 3: duplicate arrival is rejected and does not count
    arrive(1, 0, 2);
    chk("s3_stalled_first", 64'(stalled_mask), 64'b0010);
    chk("s3_err_first", 64'(err_pulse), 64'd0);
    arrive(1, 0, 2);
    chk("s3_err_dup", 64'(err_pulse), 64'd1);
    chk("s3_stalled_dup", 64'(stalled_mask), 64'b0010);
    chk("s3_rel_valid_dup", 64'(rel_valid), 64'd0);
    idle();
    chk("s3_err_pulse_end", 64'(err_pulse), 64'd0);
    arrive(0, 0, 2);
    chk("s3_no_early_release", 64'(rel_valid), 64'd0);
    chk("s3_stalled_two", 64'(stalled_mask), 64'b0011);
    arrive(3, 0, 2);
    chk("s3_rel_valid", 64'(rel_valid), 64'd1);
    chk("s3_rel_mask", 64'(rel_mask), 64'b1011);
    chk("s3_rel_bar_id", 64'(rel_bar_id), 64'd0);

    // Scenario 4: back-pressure holds the release, then back-to-back release
    rel_ready   = 1'b0;
    req_valid   = 1'b1;
    req_wid     = NW_BITS'(2);
    req_bar_id  = NB_BITS'(1);
    req_size_m1 = NW_BITS'(0);
    #1;
    chk("s4_req_ready_blocked", 64'(req_ready), 64'd0);
    step();
    $display("stall cycle -> rel_valid=%0b rel_bar=%0d rel_mask=%b", rel_valid, rel_bar_id, rel_mask);
    chk("s4_hold_valid", 64'(rel_valid), 64'd1);
    chk("s4_hold_mask", 64'(rel_mask), 64'b1011);
    chk("s4_hold_bar_id", 64'(rel_bar_id), 64'd0);
    step();
    $display("stall cycle -> rel_valid=%0b rel_bar=%0d rel_mask=%b", rel_valid, rel_bar_id, rel_mask);
    chk("s4_hold_mask2", 64'(rel_mask), 64'b1011);
    rel_ready = 1'b1;
    #1;
    chk("s4_req_ready_open", 64'(req_ready), 64'd1);
    arrive(2, 1, 0);
    chk("s4_b2b_valid", 64'(rel_valid), 64'd1);
    chk("s4_b2b_mask", 64'(rel_mask), 64'b0100);
    chk("s4_b2b_bar_id", 64'(rel_bar_id), 64'd1);
    idle();
    chk("s4_rel_cleared", 64'(rel_valid), 64'd0);
    chk("s4_rel_bar_cleared", 64'(rel_bar_id), 64'd0);

    // Scenario 5: partial barrier dropped by reset; mismatched size is ignored
    arrive(0, 2, 2);
    arrive(1, 2, 0);
    chk("s5_no_release_mismatch", 64'(rel_valid), 64'd0);
    chk("s5_stalled", 64'(stalled_mask), 64'b0011);
    chk("s5_busy", 64'(busy_mask), 64'b0100);
    reset_n = 1'b0;
    idle();
    chk("s5_busy_reset", 64'(busy_mask), 64'd0);
    chk("s5_stalled_reset", 64'(stalled_mask), 64'd0);
`ifdef BARRIER_PERF_EN
    chk("s5_perf_stall_reset", 64'(perf_stall_cycles), 64'd0);
    chk("s5_perf_rel_reset", 64'(perf_releases), 64'd0);
`endif
    reset_n = 1'b1;
    idle();
    chk("s5_no_rel_after", 64'(rel_valid), 64'd0);
    idle();
    chk("s5_no_rel_after2", 64'(rel_valid), 64'd0);
    arrive(2, 2, 2);
    chk("s5_fresh_no_rel", 64'(rel_valid), 64'd0);
    chk("s5_fresh_stalled", 64'(stalled_mask), 64'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
